// File: rtl/ssd_pkg.sv
// Shared types, segment patterns and helpers for the seven-segment display driver.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } convStateT;

    // Active-low patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter: one capture, WIDTH shifts, one update.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      num,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output convStateT             state
);

    localparam int CW = $clog2(WIDTH + 1);

    convStateT             stateNext;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratchAdj;
    logic [CW-1:0]         iterCnt;
    logic                  lastIter;

    assign lastIter = (iterCnt == CW'(WIDTH - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    stateNext = SHIFT;
            SHIFT:   if (lastIter) stateNext = UPDATE;
            UPDATE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Add-3 correction is applied before the shift, on the pre-shift nibbles
    always_comb begin
        scratchAdj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratchAdj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin     <= '0;
            scratch <= '0;
            iterCnt <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bin     <= num;
                    scratch <= '0;
                    iterCnt <= '0;
                end
                SHIFT: begin
                    {scratch, bin} <= {scratchAdj, bin} << 1;
                    iterCnt        <= iterCnt + 1'b1;
                end
                UPDATE: begin
                    bcd <= scratch;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_display_driver.sv
// Converts a binary value to BCD and time-multiplexes it onto a common-anode 7-segment display.
module ssd_display_driver
    import ssd_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int DIGITS      = 4,
    parameter int REFRESH_CNT = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      num,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (!(((64'd1 << WIDTH) - 64'd1) < pow10(DIGITS))) begin : gBadParams
        $error("ssd_display_driver: WIDTH does not fit in DIGITS decimal digits");
    end

    convStateT          convState;
    logic [RW-1:0]      rcnt;
    logic [DW-1:0]      didx;
    logic               rcntWrap;
    logic [DIGITS-1:0]  leadZero;
    logic [3:0]         curNib;
    logic [6:0]         segNext;
    logic [DIGITS-1:0]  anodeNext;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) uConv (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .bcd   (bcd),
        .busy  (busy),
        .state (convState)
    );

    assign rcntWrap = (rcnt == RW'(REFRESH_CNT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= '0;
            didx <= '0;
        end else if (rcntWrap) begin
            rcnt <= '0;
            didx <= (didx == DW'(DIGITS - 1)) ? '0 : didx + 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // A digit is blank when it and every more significant nibble are zero; digit 0 always shows
    always_comb begin
        logic allZero;
        allZero  = 1'b1;
        leadZero = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            allZero     = allZero && (bcd[4*i +: 4] == 4'd0);
            leadZero[i] = allZero;
        end
    end

    always_comb begin
        curNib    = bcd[4*didx +: 4];
        anodeNext = ~(DIGITS'(1) << didx);
        if ((BLANK_LZ != 0) && leadZero[didx]) begin
            segNext = SEG_BLANK;
        end else begin
            segNext = segDecode(curNib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode <= '1;
            seg   <= SEG_BLANK;
        end else begin
            anode <= anodeNext;
            seg   <= segNext;
        end
    end

    // busy must track the converter state exactly
    assert property (@(posedge clk) disable iff (!rst) busy == (convState != IDLE));

endmodule

// File: tb/tb_ssd_display_driver.sv
// Bench for ssd_display_driver: vector table, corner-case sequences, random stimulus vs reference model.
module tb_ssd_display_driver;

    localparam int WIDTH   = 13;
    localparam int DIGITS  = 4;
    localparam int REFRESH = 4;
    localparam int PERIOD  = WIDTH + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  num = '0;
    logic [DIGITS-1:0] anode;
    logic [6:0]        seg;
    logic [15:0]       bcd;
    logic              busy;

    int passCnt  = 0;
    int totalCnt = 0;

    int               edgeCnt = 0;
    logic [WIDTH-1:0] numHist[$];
    bit               monEn = 1'b1;

    logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic [WIDTH-1:0] num;
        logic [15:0]      expBcd;
        logic [3:0][6:0]  expSeg;
    } vecT;

    vecT vecs [6];

    // clock / reset
    always #5 clk = ~clk;

    ssd_display_driver #(
        .WIDTH       (WIDTH),
        .DIGITS      (DIGITS),
        .REFRESH_CNT (REFRESH),
        .BLANK_LZ    (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .anode (anode),
        .seg   (seg),
        .bcd   (bcd),
        .busy  (busy)
    );

    always @(posedge clk) begin
        if (rst) begin
            edgeCnt++;
            numHist.push_back(num);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s (edge %0d): got %0h, want %0h", name, edgeCnt, act, exp);
    endtask

    // reference model: conversions complete every PERIOD edges from the num seen at each capture edge
    function automatic int modelVal(input int k);
        if (k < PERIOD) return 0;
        return int'(numHist[PERIOD * (k / PERIOD) - PERIOD]);
    endfunction

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int digitAt(input int k);
        return ((k - 1) / REFRESH) % DIGITS;
    endfunction

    function automatic logic [6:0] modelSeg(input int k);
        int v;
        int d;
        int p;
        v = modelVal(k - 1);
        d = digitAt(k);
        p = 10 ** d;
        if (d > 0 && v < p) return 7'b1111111;
        return segTab[(v / p) % 10];
    endfunction

    function automatic logic [3:0] oneCold(input int d);
        logic [3:0] a;
        a = 4'b0001 << d;
        return ~a;
    endfunction

    task automatic checkResetVals(input string tag);
        check({tag, "_anode"}, 32'(anode), 32'hF);
        check({tag, "_seg"},   32'(seg),   32'h7F);
        check({tag, "_bcd"},   32'(bcd),   32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    // scoreboard: every negedge compares all outputs against the model
    always @(negedge clk) begin
        if (monEn) begin
            if (!rst || edgeCnt == 0) begin
                checkResetVals("mon_rst");
            end else begin
                check("mon_bcd",   32'(bcd),   32'(toBcd(modelVal(edgeCnt))));
                check("mon_anode", 32'(anode), 32'(oneCold(digitAt(edgeCnt))));
                check("mon_seg",   32'(seg),   32'(modelSeg(edgeCnt)));
                check("mon_busy",  32'(busy),  32'((edgeCnt % PERIOD) != 0));
            end
        end
    end

    // driver tasks
    task automatic doReset(input logic [WIDTH-1:0] n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        edgeCnt = 0;
        numHist.delete();
        num = n;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vecs[0] = '{13'd1234, 16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{13'd8191, 16'h8191, {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001}};
        vecs[2] = '{13'd7,    16'h0007, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[3] = '{13'd0,    16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[4] = '{13'd1000, 16'h1000, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[5] = '{13'd42,   16'h0042, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}};

        // reset held with clock running
        repeat (4) @(negedge clk);
        #1;
        checkResetVals("reset_hold");

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            doReset(vecs[v].num);
            repeat (PERIOD - 1) @(negedge clk);
            check("latency_pre", 32'(bcd), 32'h0);
            @(negedge clk);
            check("vec_bcd", 32'(bcd), 32'(vecs[v].expBcd));
            repeat (3) @(negedge clk);
            for (int d = 0; d < DIGITS; d++) begin
                check("vec_anode", 32'(anode), 32'(oneCold(d)));
                check("vec_seg",   32'(seg),   32'(vecs[v].expSeg[d]));
                repeat (REFRESH) @(negedge clk);
            end
        end

        // num changes mid-SHIFT: current conversion keeps the old value
        doReset(13'd100);
        repeat (6) @(negedge clk);
        num = 13'd200;
        repeat (PERIOD - 6) @(negedge clk);
        check("midchg_first", 32'(bcd), 32'h0100);
        repeat (PERIOD - 1) @(negedge clk);
        check("midchg_hold", 32'(bcd), 32'h0100);
        @(negedge clk);
        check("midchg_second", 32'(bcd), 32'h0200);

        // async reset between edges, in the middle of a second conversion
        doReset(13'd300);
        repeat (PERIOD) @(negedge clk);
        check("pre_abort_bcd", 32'(bcd), 32'h0300);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        edgeCnt = 0;
        numHist.delete();
        #1;
        checkResetVals("async_rst");
        @(negedge clk);
        num = 13'd42;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (PERIOD - 1) @(negedge clk);
        check("restart_pre", 32'(bcd), 32'h0);
        @(negedge clk);
        check("restart_bcd", 32'(bcd), 32'h0042);

        // random stimulus, scoreboard does the checking
        doReset(WIDTH'($urandom_range(0, 8191)));
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            num = WIDTH'($urandom_range(0, 8191));
        end
        repeat (2 * PERIOD + 2 * REFRESH * DIGITS) @(negedge clk);

        monEn = 1'b0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/ssd_display_driver.md
# ssd_display_driver

Downstream consumer of the CPU top's 13-bit `SSD` debug value. Each value is converted to four BCD digits with a sequential double-dabble engine. The block then time-multiplexes the digits onto a 4-digit common-anode seven-segment display. It replaces direct binary display on the board and runs on the CPU board clock with an internal refresh prescaler.

## Interface
Parameters:
- `WIDTH`, 13: binary input width.
- `DIGITS`, 4: display digits. Elaboration must fail unless 2^WIDTH−1 < 10^DIGITS.
- `REFRESH_CNT`, 100000: clock cycles each digit stays enabled.
- `BLANK_LZ`, 1: blank leading zeros when 1.

Ports:
- `clk`, in, 1: single clock; all flops on rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `num`, in, WIDTH: binary value to display (driven from the CPU `SSD` output).
- `anode`, out, DIGITS: digit enables, active-low; bit 0 is the ones digit.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `bcd`, out, 4·DIGITS: BCD value currently displayed; also used for verification.
- `busy`, out, 1: high while a conversion is in flight.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, UPDATE.
  - IDLE (1 cycle): capture `num` into shift register `bin`, clear scratch BCD, clear iteration count, go to SHIFT.
  - SHIFT (WIDTH cycles): first add 3 to every scratch nibble ≥ 5, then shift {scratch, `bin`} left by 1. After WIDTH iterations, go to UPDATE.
  - UPDATE (1 cycle): copy scratch to `bcd`, go to IDLE.
- Conversion is free-running: a new capture starts every WIDTH+2 cycles.
- A change on `num` during SHIFT/UPDATE does not affect the current conversion; the next IDLE picks it up.
- `busy` = 1 in SHIFT and UPDATE, 0 in IDLE.
- No overflow is possible under the parameter check; scratch width is 4·DIGITS.
- Refresh:
  - Counter `rcnt` counts 0..REFRESH_CNT−1.
  - At terminal count it wraps to 0 and digit index `didx` advances mod DIGITS (3 → 0).
- Output registers, updated every cycle:
  - `anode` = one-cold on `didx`.
  - `seg` = decode of `bcd` nibble `didx`.
- Decode, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibble > 9 (unreachable) = 1111111.
- Blanking with BLANK_LZ=1: a digit whose nibble and all higher nibbles are zero shows `seg` = 1111111. Digit 0 is never blanked, so value 0 shows "0".

## Timing
- Reset values (immediate on `rst` low, independent of `clk`):
  - `anode` = all 1s, `seg` = 1111111, `bcd` = 0, `busy` = 0.
  - FSM = IDLE; `rcnt`, `didx`, iteration count = 0.
- First edge after `rst` rises:
  - FSM captures `num`.
  - `anode` = …1110 and `seg` = "0" pattern (`bcd` still 0).
- Latency from the IDLE capture edge to `bcd` valid: WIDTH+2 edges (15 for defaults). Worst case from a `num` change: 2·(WIDTH+2)−1 cycles.
- `anode`/`seg` follow `bcd` and `didx` with one register stage.
- A digit change happens on the edge where `rcnt` wraps. Each digit is lit exactly REFRESH_CNT cycles.
- `rst` asserted mid-SHIFT aborts the conversion; nothing partial reaches `bcd`. After release, the conversion restarts from IDLE.

## Structure
- Shared package `ssd_pkg` holds:
  - FSM state enum (IDLE/SHIFT/UPDATE).
  - 7-bit segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Digit decode function.
- Sub-module `bin2bcd_seq` holds the IDLE/SHIFT/UPDATE engine, with ports `num`, `bcd`, `busy`.
- The top holds the refresh counter, digit mux, blanking, and output registers.

## Test plan
- Reset: hold `rst`=0 with clock running → `anode`=1111, `seg`=1111111, `bcd`=0, `busy`=0 throughout; same after async assert between edges.
- Basic conversion, `num`=1234, REFRESH_CNT=4:
  - `bcd`=16'h1234 within 15 cycles.
  - `anode` sequence 1110, 1101, 1011, 0111, each for 4 cycles.
  - `seg` = 0011001, 0110000, 0100100, 1111001.
- Maximum value: `num`=8191 → `bcd`=16'h8191; digit 3 `seg` = 0000000.
- Blanking:
  - `num`=7 → digits 1–3 `seg`=1111111, digit 0 = 1111000.
  - `num`=0 → digit 0 = 1000000.
  - `num`=1000 → no digit blanked.
- Mid-conversion change: `num`=100, switch to 200 at cycle 5 of SHIFT → `bcd` first 16'h0100, then 16'h0200 one conversion period later; never an intermediate value.
- Reset mid-SHIFT: assert `rst` at SHIFT iteration 6 → outputs at reset values immediately; after release with `num`=42, `bcd`=16'h0042 after 15 edges.
